// File: rtl/stack_arb_cntrl_pkg.sv
// Types and constants shared by the arbitrated LIFO stack controller.
package stack_pkg;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_t;

    // Two slots cover the one response held in s1 plus the one waiting at the output.
    localparam int RSP_FIFO_DEPTH = 2;

endpackage

// File: rtl/stack_arb_cntrl_if.sv
// Request, response and SRAM signal bundle for stack_arb_cntrl.
interface stack_arb_cntrl_if #(
    parameter int N = 16,
    parameter int W = 32,
    parameter int R = 4
);
    localparam int ADDR_W = $clog2(N);
    localparam int CNT_W  = $clog2(N + 1);
    localparam int ID_W   = $clog2(R);

    logic [R-1:0]      i_req_vld;
    logic [R-1:0]      i_req_op;
    logic [R*W-1:0]    i_req_dat;
    logic [R-1:0]      o_req_rdy;
    logic              o_rsp_vld;
    logic              i_rsp_rdy;
    logic [ID_W-1:0]   o_rsp_id;
    logic [W-1:0]      o_rsp_dat;
    logic              o_rsp_err;
    logic              o_mem_wen;
    logic              o_mem_ren;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [W-1:0]      o_mem_wdat;
    logic [W-1:0]      i_mem_rdat;
    logic [CNT_W-1:0]  o_cnt;
    logic              o_full;
    logic              o_empty;

    modport slave (
        input  i_req_vld, i_req_op, i_req_dat, i_rsp_rdy, i_mem_rdat,
        output o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_dat, o_rsp_err,
               o_mem_wen, o_mem_ren, o_mem_addr, o_mem_wdat, o_cnt, o_full, o_empty
    );

    modport master (
        output i_req_vld, i_req_op, i_req_dat, i_rsp_rdy, i_mem_rdat,
        input  o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_dat, o_rsp_err,
               o_mem_wen, o_mem_ren, o_mem_addr, o_mem_wdat, o_cnt, o_full, o_empty
    );

endinterface

// File: rtl/stack_arb_cntrl_rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at ptr; ptr moves past each winner.
module rr_arb #(
    parameter int R = 4
) (
    input  logic         clk,
    input  logic         arst,
    input  logic [R-1:0] req,
    input  logic         grant_en,
    output logic [R-1:0] gnt
);
    localparam int PTR_W = $clog2(R);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < R; i++) begin
            idx = int'(ptr) + i;
            if (idx >= R) idx = idx - R;
            if (grant_en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_nxt  = (idx == R - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) ptr <= '0;
        else      ptr <= ptr_nxt;
    end

endmodule

// File: rtl/stack_arb_cntrl.sv
// Shares one single-port SRAM LIFO among R requesters: RR grant, SRAM sequencing, stack
// pointer and an in-order, backpressured response channel with a fixed two-cycle latency.
module stack_arb_cntrl
    import stack_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 32,
    parameter int R = 4
) (
    input logic              clk,
    input logic              arst,
    stack_arb_cntrl_if.slave bus
);
    localparam int ADDR_W = $clog2(N);
    localparam int CNT_W  = $clog2(N + 1);
    localparam int ID_W   = $clog2(R);
    localparam int FCNT_W = $clog2(RSP_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [W-1:0]    dat;
        logic            err;
    } rsp_t;

    logic [R-1:0]      gnt;
    logic              grant_en, granted, rsp_pop;
    logic [ID_W-1:0]   gnt_id;
    op_t               gnt_op;
    logic [W-1:0]      gnt_dat;
    logic              gnt_wr, gnt_rd, gnt_err;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              full, empty;
    logic              s1_vld, s1_err, s1_rd;
    logic [ID_W-1:0]   s1_id;
    rsp_t              s1_rsp, head;
    rsp_t              fifo_mem [RSP_FIFO_DEPTH];
    logic              wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;

    // A grant is allowed only if its response is guaranteed a FIFO slot two cycles later.
    assign rsp_pop  = bus.o_rsp_vld & bus.i_rsp_rdy;
    assign grant_en = ~arst &
        ((fifo_cnt - FCNT_W'(rsp_pop) + FCNT_W'(s1_vld)) < FCNT_W'(RSP_FIFO_DEPTH));

    rr_arb #(.R(R)) u_arb (
        .clk      (clk),
        .arst     (arst),
        .req      (bus.i_req_vld),
        .grant_en (grant_en),
        .gnt      (gnt)
    );

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < R; i++)
            if (gnt[i]) gnt_id = ID_W'(i);
    end

    assign granted = |gnt;
    assign gnt_op  = op_t'(bus.i_req_op[gnt_id]);
    assign gnt_dat = bus.i_req_dat[gnt_id*W +: W];
    assign gnt_wr  = granted && (gnt_op == OP_PUSH) && !full;
    assign gnt_rd  = granted && (gnt_op == OP_POP) && !empty;
    assign gnt_err = granted && !gnt_wr && !gnt_rd;

    assign bus.o_req_rdy  = gnt;
    assign bus.o_mem_wen  = gnt_wr;
    assign bus.o_mem_ren  = gnt_rd;
    assign bus.o_mem_addr = gnt_rd ? ADDR_W'(cnt - 1'b1) : (gnt_wr ? ADDR_W'(cnt) : '0);
    assign bus.o_mem_wdat = gnt_wr ? gnt_dat : '0;

    always_comb begin
        cnt_nxt = cnt;
        if (gnt_wr)      cnt_nxt = cnt + 1'b1;
        else if (gnt_rd) cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            s1_vld <= 1'b0;
            s1_id  <= '0;
            s1_err <= 1'b0;
            s1_rd  <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            full   <= (cnt_nxt == CNT_W'(N));
            empty  <= (cnt_nxt == '0);
            s1_vld <= granted;
            s1_id  <= gnt_id;
            s1_err <= gnt_err;
            s1_rd  <= gnt_rd;
        end
    end

    // SRAM read data is only valid in the cycle after the strobe, which is when s1 holds the op.
    always_comb begin
        s1_rsp.id  = s1_id;
        s1_rsp.dat = s1_rd ? bus.i_mem_rdat : '0;
        s1_rsp.err = s1_err;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            if (s1_vld)  wr_ptr <= ~wr_ptr;
            if (rsp_pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + FCNT_W'(s1_vld) - FCNT_W'(rsp_pop);
        end
    end

    // NOTE: the FIFO storage is not reset; fifo_cnt gates its visibility, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (s1_vld) fifo_mem[wr_ptr] <= s1_rsp;
    end

    assign head          = fifo_mem[rd_ptr];
    assign bus.o_rsp_vld = (fifo_cnt != '0);
    assign bus.o_rsp_id  = head.id;
    assign bus.o_rsp_dat = head.dat;
    assign bus.o_rsp_err = head.err;
    assign bus.o_cnt     = cnt;
    assign bus.o_full    = full;
    assign bus.o_empty   = empty;

endmodule

// File: tb/tb_stack_arb_cntrl.sv
// Bench for stack_arb_cntrl: directed vector table, multi-cycle corner sequences and a random
// run checked against a queue-based LIFO / round-robin / credit reference.
module tb_stack_arb_cntrl;
    import stack_pkg::*;

    localparam int N      = 4;
    localparam int W      = 32;
    localparam int R      = 4;
    localparam int ID_W   = $clog2(R);
    localparam int ADDR_W = $clog2(N);
    localparam int CNT_W  = $clog2(N + 1);

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    stack_arb_cntrl_if #(.N(N), .W(W), .R(R)) bus ();

    stack_arb_cntrl #(.N(N), .W(W), .R(R)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    // SRAM macro model: synchronous write, registered read.
    logic [W-1:0] sram [N];
    always @(posedge clk) begin
        if (bus.o_mem_wen) sram[bus.o_mem_addr] <= bus.o_mem_wdat;
        if (bus.o_mem_ren) bus.i_mem_rdat <= sram[bus.o_mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model state.
    typedef struct {
        int           id;
        logic [W-1:0] dat;
        logic         err;
        int           cyc;
    } exp_rsp_t;

    exp_rsp_t     exp_q[$];
    logic [W-1:0] model_stack[$];
    int           rr_ptr;
    int           cyc = 0;
    int           model_grants;
    bit           mon_en;

    // Per-cycle samples of DUT outputs taken at the falling edge.
    logic [R-1:0]      s_rdy;
    logic              s_wen, s_ren, s_rsp_vld, s_rsp_err, s_full, s_empty;
    logic [ADDR_W-1:0] s_addr;
    logic [ID_W-1:0]   s_rsp_id;
    logic [W-1:0]      s_rsp_dat;
    logic [CNT_W-1:0]  s_cnt;

    task automatic reset_model();
        exp_q.delete();
        model_stack.delete();
        rr_ptr = 0;
    endtask

    task automatic monitor();
        logic         exp_vld, op, ew, er;
        logic [R-1:0] exp_gnt;
        logic [W-1:0] d;
        int           sel, ea;
        exp_rsp_t     e;

        check("cnt",   64'(bus.o_cnt),   64'(model_stack.size()));
        check("full",  64'(bus.o_full),  64'(model_stack.size() == N));
        check("empty", 64'(bus.o_empty), 64'(model_stack.size() == 0));

        exp_vld = (exp_q.size() > 0) && ((cyc - exp_q[0].cyc) >= 2);
        check("rsp_vld", 64'(bus.o_rsp_vld), 64'(exp_vld));
        if (exp_vld) begin
            check("rsp_id",  64'(bus.o_rsp_id),  64'(exp_q[0].id));
            check("rsp_dat", 64'(bus.o_rsp_dat), 64'(exp_q[0].dat));
            check("rsp_err", 64'(bus.o_rsp_err), 64'(exp_q[0].err));
            if (bus.i_rsp_rdy) void'(exp_q.pop_front());
        end

        exp_gnt = '0;
        sel     = 0;
        if (exp_q.size() < 2) begin
            for (int i = 0; i < R; i++) begin
                int k;
                k = (rr_ptr + i) % R;
                if (exp_gnt == '0 && bus.i_req_vld[k]) begin
                    exp_gnt[k] = 1'b1;
                    sel        = k;
                end
            end
        end
        check("req_rdy", 64'(bus.o_req_rdy), 64'(exp_gnt));

        ew = 1'b0;
        er = 1'b0;
        ea = 0;
        d  = '0;
        if (exp_gnt != '0) begin
            rr_ptr = (sel + 1) % R;
            model_grants++;
            op    = bus.i_req_op[sel];
            d     = bus.i_req_dat[sel*W +: W];
            e.id  = sel;
            e.cyc = cyc;
            e.dat = '0;
            e.err = 1'b0;
            if (op == OP_PUSH) begin
                if (model_stack.size() < N) begin
                    ew = 1'b1;
                    ea = model_stack.size();
                    model_stack.push_back(d);
                end else e.err = 1'b1;
            end else begin
                if (model_stack.size() > 0) begin
                    er    = 1'b1;
                    ea    = model_stack.size() - 1;
                    e.dat = model_stack.pop_back();
                end else e.err = 1'b1;
            end
            exp_q.push_back(e);
        end
        check("mem_wen", 64'(bus.o_mem_wen), 64'(ew));
        check("mem_ren", 64'(bus.o_mem_ren), 64'(er));
        if (ew || er) check("mem_addr", 64'(bus.o_mem_addr), 64'(ea));
        if (ew)       check("mem_wdat", 64'(bus.o_mem_wdat), 64'(d));
    endtask

    // One clock: sample and check at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        s_rdy     = bus.o_req_rdy;
        s_wen     = bus.o_mem_wen;
        s_ren     = bus.o_mem_ren;
        s_addr    = bus.o_mem_addr;
        s_rsp_vld = bus.o_rsp_vld;
        s_rsp_id  = bus.o_rsp_id;
        s_rsp_dat = bus.o_rsp_dat;
        s_rsp_err = bus.o_rsp_err;
        s_cnt     = bus.o_cnt;
        s_full    = bus.o_full;
        s_empty   = bus.o_empty;
        if (mon_en) monitor();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int           id;
        logic         op;
        logic [W-1:0] dat;
        logic         wen;
        logic         ren;
        int           addr;
        logic         err;
        logic [W-1:0] rdat;
        int           cnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int  ngr, nrsp;
        bit  got;

        for (int i = 0; i < 4; i++)
            vecs[i] = '{0, OP_PUSH, 32'hA + i, 1'b1, 1'b0, i, 1'b0, 32'h0, i + 1};
        vecs[4] = '{0, OP_PUSH, 32'hE, 1'b0, 1'b0, 0, 1'b1, 32'h0, 4};
        for (int j = 0; j < 4; j++)
            vecs[5 + j] = '{2, OP_POP, 32'h0, 1'b0, 1'b1, 3 - j, 1'b0, 32'hD - j, 3 - j};
        vecs[9] = '{2, OP_POP, 32'h0, 1'b0, 1'b0, 0, 1'b1, 32'h0, 0};

        // Reset with every requester asking: nothing may be granted.
        arst          = 1'b1;
        mon_en        = 1'b0;
        model_grants  = 0;
        bus.i_req_vld = '1;
        bus.i_req_op  = '0;
        bus.i_req_dat = '0;
        bus.i_rsp_rdy = 1'b1;
        reset_model();
        tick();
        check("rst_req_rdy", 64'(s_rdy),     64'(0));
        check("rst_rsp_vld", 64'(s_rsp_vld), 64'(0));
        check("rst_cnt",     64'(s_cnt),     64'(0));
        check("rst_empty",   64'(s_empty),   64'(1));
        check("rst_full",    64'(s_full),    64'(0));
        check("rst_wen",     64'(s_wen),     64'(0));
        check("rst_ren",     64'(s_ren),     64'(0));
        bus.i_req_vld = '0;
        arst          = 1'b0;
        mon_en        = 1'b1;
        tick();

        // Directed table: fill, overflow, drain, underflow.
        for (int v = 0; v < 10; v++) begin
            bus.i_req_op                      = '0;
            bus.i_req_dat                     = '0;
            bus.i_req_op[vecs[v].id]          = vecs[v].op;
            bus.i_req_dat[vecs[v].id*W +: W]  = vecs[v].dat;
            bus.i_req_vld                     = '0;
            bus.i_req_vld[vecs[v].id]         = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                tick();
                got = s_rdy[vecs[v].id];
            end
            bus.i_req_vld = '0;
            check("tbl_grant", 64'(got), 64'(1));
            if (got) begin
                check("tbl_wen", 64'(s_wen), 64'(vecs[v].wen));
                check("tbl_ren", 64'(s_ren), 64'(vecs[v].ren));
                if (vecs[v].wen || vecs[v].ren)
                    check("tbl_addr", 64'(s_addr), 64'(vecs[v].addr));
            end
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                tick();
                got = s_rsp_vld;
            end
            check("tbl_rsp", 64'(got), 64'(1));
            if (got) begin
                check("tbl_id",    64'(s_rsp_id),  64'(vecs[v].id));
                check("tbl_dat",   64'(s_rsp_dat), 64'(vecs[v].rdat));
                check("tbl_err",   64'(s_rsp_err), 64'(vecs[v].err));
                check("tbl_cnt",   64'(s_cnt),     64'(vecs[v].cnt));
                check("tbl_full",  64'(s_full),    64'(vecs[v].cnt == N));
                check("tbl_empty", 64'(s_empty),   64'(vecs[v].cnt == 0));
            end
        end

        // Push from req1 immediately followed by a pop of the same entry from req3.
        bus.i_req_op             = '0;
        bus.i_req_op[3]          = OP_POP;
        bus.i_req_dat            = '0;
        bus.i_req_dat[1*W +: W]  = 32'h55;
        bus.i_req_vld            = 4'b0010;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            tick();
            got = s_rdy[1];
        end
        check("b2b_push_grant", 64'(got), 64'(1));
        bus.i_req_vld = 4'b1000;
        tick();
        bus.i_req_vld = '0;
        check("b2b_pop_grant", 64'(s_rdy),  64'(4'b1000));
        check("b2b_pop_ren",   64'(s_ren),  64'(1));
        check("b2b_pop_addr",  64'(s_addr), 64'(0));
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            tick();
            got = s_rsp_vld && (s_rsp_id == ID_W'(3));
        end
        check("b2b_rsp", 64'(got), 64'(1));
        check("b2b_dat", 64'(s_rsp_dat), 64'(32'h55));
        check("b2b_err", 64'(s_rsp_err), 64'(0));

        // Response backpressure: exactly two grants, then all held off until released.
        bus.i_rsp_rdy = 1'b0;
        bus.i_req_op  = '0;
        for (int i = 0; i < R; i++) bus.i_req_dat[i*W +: W] = 32'h100 + i;
        bus.i_req_vld = '1;
        ngr = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            ngr += $countones(s_rdy);
            bus.i_req_vld &= ~s_rdy;
        end
        check("bp_grants", 64'(ngr),   64'(2));
        check("bp_rdy_low", 64'(s_rdy), 64'(0));
        bus.i_rsp_rdy = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 40 && (bus.i_req_vld != '0 || exp_q.size() != 0); c++) begin
            tick();
            nrsp += int'(s_rsp_vld);
            bus.i_req_vld &= ~s_rdy;
        end
        check("bp_rsp_count", 64'(nrsp), 64'(4));

        // Reset while s1 and the response FIFO both hold pops.
        bus.i_rsp_rdy = 1'b0;
        bus.i_req_op  = '1;
        bus.i_req_vld = '1;
        for (int c = 0; c < 3; c++) begin
            tick();
            bus.i_req_vld &= ~s_rdy;
        end
        arst   = 1'b1;
        mon_en = 1'b0;
        tick();
        check("mid_rst_rsp_vld", 64'(s_rsp_vld), 64'(0));
        check("mid_rst_cnt",     64'(s_cnt),     64'(0));
        check("mid_rst_empty",   64'(s_empty),   64'(1));
        check("mid_rst_wen",     64'(s_wen),     64'(0));
        check("mid_rst_ren",     64'(s_ren),     64'(0));
        check("mid_rst_rdy",     64'(s_rdy),     64'(0));

        // After reset, all requesters pushing every cycle: grants 0,1,2,3,0.
        arst = 1'b0;
        reset_model();
        mon_en        = 1'b1;
        bus.i_rsp_rdy = 1'b1;
        bus.i_req_op  = '0;
        for (int i = 0; i < R; i++) bus.i_req_dat[i*W +: W] = 32'h200 + i;
        bus.i_req_vld = '1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rr_grant", 64'(s_rdy), 64'(1) << (c % R));
        end
        bus.i_req_vld = '0;
        for (int c = 0; c < 4; c++) tick();

        // Randomized traffic with hold-until-accepted requesters and random response backpressure.
        model_grants = 0;
        nrsp         = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < R; i++) begin
                if (!bus.i_req_vld[i] && $urandom_range(0, 99) < 40) begin
                    bus.i_req_vld[i]         = 1'b1;
                    bus.i_req_op[i]          = ($urandom_range(0, 99) < 50);
                    bus.i_req_dat[i*W +: W]  = $urandom;
                end
            end
            bus.i_rsp_rdy = ($urandom_range(0, 99) < 70);
            tick();
            nrsp += int'(s_rsp_vld && bus.i_rsp_rdy);
            bus.i_req_vld &= ~s_rdy;
        end
        bus.i_req_vld = '0;
        bus.i_rsp_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            nrsp += int'(s_rsp_vld);
        end
        check("rand_rsp_count", 64'(nrsp), 64'(model_grants));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
